// File: rtl/hex_scan_display.sv
// hex_scan_display: multiplexed seven-segment scanner with tear-free frame
// commit, anti-ghost guard interval, leading-zero blanking and selectable
// output polarity. Outputs are fully registered.
module hex_scan_display #(
   parameter int DIGITS     = 4,
   parameter int DIV        = 50_000,
   parameter int GUARD      = 2,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [4*DIGITS-1:0]   i_value,
   input  logic [DIGITS-1:0]     i_dp,
   input  logic                  i_load,
   input  logic                  i_lzb,
   input  logic                  i_blank,
   output logic [6:0]            o_seg,
   output logic                  o_dp,
   output logic [DIGITS-1:0]     o_an,
   output logic                  o_frame
);

   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int GRD_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(DIGITS - 1);
   localparam logic [GRD_W-1:0] GRD_INIT = GRD_W'(GUARD);
   localparam logic             POL      = (ACTIVE_LOW != 0);

   // Hex nibble to active-high segment pattern (bit0 = a ... bit6 = g).
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      case (nib)
         4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
      endcase
   endfunction

   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [GRD_W-1:0]    guard_q, guard_d;
   logic [4*DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                frame_q, frame_d;

   logic                tick, wrap;
   logic [3:0]          nib;
   logic                dp_bit, zero_above, lz_blank, lit;
   logic [DIGITS-1:0]   an_raw;

   // Scan timing, guard countdown and pending/display register updates.
   always_comb begin
      tick       = (pre_q == PRE_MAX);
      wrap       = tick && (idx_q == IDX_MAX);
      pre_d      = tick ? '0 : pre_q + PRE_W'(1);
      idx_d      = idx_q;
      if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
      guard_d    = guard_q;
      if (tick)                 guard_d = GRD_INIT;
      else if (guard_q != '0)   guard_d = guard_q - GRD_W'(1);
      pend_val_d = i_load ? i_value : pend_val_q;
      pend_dp_d  = i_load ? i_dp    : pend_dp_q;
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      // A load on the wrapping tick itself goes straight to the display.
      if (wrap) begin
         disp_val_d = pend_val_d;
         disp_dp_d  = pend_dp_d;
      end
      frame_d    = wrap;
   end

   // Output decode for the digit that is current after this edge.
   always_comb begin
      nib        = 4'h0;
      dp_bit     = 1'b0;
      zero_above = 1'b1;
      an_raw     = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_d == IDX_W'(k)) begin
            nib    = disp_val_d[4*k +: 4];
            dp_bit = disp_dp_d[k];
         end
         if ((IDX_W'(k) >= idx_d) && (disp_val_d[4*k +: 4] != 4'h0))
            zero_above = 1'b0;
      end
      lz_blank = i_lzb && (idx_d != '0) && zero_above;
      lit      = (guard_d == '0) && !i_blank && !lz_blank;
      for (int k = 0; k < DIGITS; k++)
         an_raw[k] = lit && (idx_d == IDX_W'(k));
      seg_d = (lit ? seg7(nib) : 7'h00) ^ {7{POL}};
      dp_d  = (lit & dp_bit) ^ POL;
      an_d  = an_raw ^ {DIGITS{POL}};
   end

   // State and output registers; reset drives outputs to the inactive level.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         pre_q      <= '0;
         idx_q      <= '0;
         guard_q    <= GRD_INIT;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         disp_val_q <= '0;
         disp_dp_q  <= '0;
         seg_q      <= {7{POL}};
         dp_q       <= POL;
         an_q       <= {DIGITS{POL}};
         frame_q    <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         guard_q    <= guard_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
         frame_q    <= frame_d;
      end
   end

   assign o_seg   = seg_q;
   assign o_dp    = dp_q;
   assign o_an    = an_q;
   assign o_frame = frame_q;

endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Parametrised multiplexed seven-segment display controller for the board top level. It latches a packed hex value of DIGITS nibbles plus decimal points and scans one digit at a time at a prescaled rate. New values commit tear-free at frame boundaries. It adds an anti-ghost guard interval, leading-zero blanking, a global blank and selectable output polarity, replacing the fixed two-digit, always-on hex driver.

## Interface
- DIGITS, 4: number of digits scanned; ≥ 1.
- DIV, 50_000: i_clock cycles per digit slot; ≥ 2.
- GUARD, 2: cycles per slot with all anodes off after a digit switch; 0 ≤ GUARD < DIV.
- ACTIVE_LOW, 1: 1 means o_seg, o_dp and o_an are active-low; 0 means active-high.
- i_clock  in  1  single clock domain for the whole block.
- i_reset  in  1  asynchronous, active-high reset.
- i_value  in  4*DIGITS  hex value; nibble k drives digit k, and digit 0 is least significant.
- i_dp  in  DIGITS  decimal point per digit.
- i_load  in  1  one-cycle strobe that captures i_value and i_dp into the pending register.
- i_lzb  in  1  enables leading-zero blanking.
- i_blank  in  1  forces every anode inactive.
- o_seg  out  7  segments; bit0 = a … bit6 = g.
- o_dp  out  1  decimal point of the current digit.
- o_an  out  DIGITS  one-hot digit enable.
- o_frame  out  1  one-cycle pulse at the start of each frame.

## Operation
- **Prescaler:** counts 0..DIV-1 and wraps. A tick occurs on the cycle where the count equals DIV-1.
- **Digit index:** counts 0..DIGITS-1 and advances on each tick, wrapping DIGITS-1 → 0.
- **Pending register:** loaded on i_load. Back-to-back loads overwrite it; the last one wins.
- **Display register:** committed on the tick that wraps the index to 0.
  - The committed value is i_value/i_dp if i_load is high on that same cycle; otherwise it is the pending value.
  - Pending is also updated in that case.
- **Decode:** registered, from the display nibble selected by the index. All values below are active-high.
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
- **Leading-zero blanking:** digit k (k>0) is blanked when i_lzb=1 and display nibbles DIGITS-1..k are all 0. Digit 0 is never blanked by this rule.
- **Anode enable:** o_an has a bit set only for the current index, and only when:
  - the guard counter has expired,
  - i_blank=0,
  - the digit is not leading-zero blanked.
  
  o_seg and o_dp are forced to the inactive level whenever o_an is fully inactive.
- **Polarity:** with ACTIVE_LOW=1, o_seg, o_dp and o_an are bitwise inverted at the output register.
- **Frame pulse:** o_frame is high for exactly one cycle, on the cycle the index becomes 0.

## Timing
- **Reset (asynchronous):**
  - Prescaler, index, pending and display registers clear to 0.
  - The guard counter loads GUARD.
  - o_an, o_seg and o_dp go inactive immediately, with no clock edge needed. o_frame = 0.
- **After reset release:**
  - Digit 0 (value 0) becomes active after GUARD cycles.
  - The first tick occurs at the DIV-th cycle.
- **Digit switch:** on the edge after a tick, index, o_seg and o_dp update. o_an is inactive for GUARD cycles, then active for DIV-GUARD cycles.
- **Frame timing:** frame period is DIGITS*DIV cycles. Load-to-display latency is at most DIGITS*DIV + 1 cycles.
- **Input changes:** i_blank and i_lzb take effect on o_an one cycle after they change.
- **Reset mid-frame:** discards pending loads; no partial frame completes.

## Test plan
All scenarios use DIGITS=4, DIV=8, GUARD=2, ACTIVE_LOW=0 unless stated.

1. **Reset.** Assert i_reset mid-slot between clock edges, then release.
   - While asserted: o_an=0000, o_seg=00, o_dp=0, immediately.
   - After release: o_an=0001 with o_seg=3F from cycle 2. o_frame pulses every 32 cycles, and digits advance every 8.
2. **Decode.** Load 0x12AF, i_dp=0100, i_lzb=0.
   - After the next frame boundary: digit0 o_seg=71, digit1 77, digit2 5B with o_dp=1, digit3 06.
   - Each digit has o_an low for the first 2 cycles of its slot.
3. **Leading-zero blanking.**
   - Load 0x0005 with i_lzb=1: o_an only ever shows 0001, with o_seg=6D; slots 1-3 are fully dark.
   - Load 0x0000: digit0 shows 3F.
   - Load 0x0500: digits 2, 1 and 0 are lit.
4. **Tear-free update.** Display holds 0x1111. Load 0x2222 during slot 2, then 0x3333 during slot 3.
   - Slots 2 and 3 keep showing 06.
   - The next frame shows 4F on all digits; 0x2222 is never displayed.
5. **Simultaneous events.** Pulse i_load with 0x4444 on the exact tick that wraps the index to 3→0.
   - Digit0 of the new frame shows 66, and o_frame pulses that cycle.
6. **Polarity and blank.** ACTIVE_LOW=1, hold i_blank=1.
   - o_an=1111, o_seg=7F, o_dp=1 throughout.
   - o_frame still pulses every 32 cycles.
   - Release i_blank: the lit anode goes low one cycle later.
